// File: rtl/riscv_dbg_responder.sv
// riscv_dbg_responder: core-side end of the per-core debug bus.
// Serves host reads/writes of the debug registers, GPRs and NPC, and pulses
// cpu_bp_o on single-step, enabled ebreak/exceptions or hardware breakpoints.
// Optional feature macro: RISCV_DBG_HWBP_EN (adds NBP address comparators).
module riscv_dbg_responder #(
  parameter int XLEN = 64,
  parameter int PLEN = 64,
  parameter int NBP  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_stall_i,
  input  logic            cpu_stb_i,
  input  logic            cpu_we_i,
  input  logic [PLEN-1:0] cpu_adr_i,
  input  logic [XLEN-1:0] cpu_dat_i,
  output logic [XLEN-1:0] cpu_dat_o,
  output logic            cpu_ack_o,
  output logic            cpu_bp_o,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_ebreak_i,
  input  logic            ex_exc_i,
  input  logic [3:0]      ex_cause_i,
  output logic [4:0]      gpr_idx_o,
  output logic            gpr_re_o,
  output logic            gpr_we_o,
  output logic [XLEN-1:0] gpr_wdat_o,
  input  logic [XLEN-1:0] gpr_rdat_i,
  output logic            npc_we_o,
  output logic [XLEN-1:0] npc_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK, ST_WAIT} state_t;

  state_t            state_reg;
  logic              ctrl_reg;
  logic [3:0]        hit_reg;
  logic [15:0]       ie_reg;
  logic [3:0]        cause_reg;
  logic [XLEN-1:0]   npc_reg;
  logic [XLEN-1:0]   rdata_reg;
  logic              rd_gpr_reg;

  // Only the low 16 address bits are decoded; the rest are deliberately ignored.
  logic [15:0] adr;
  logic        unused_adr_hi;
  assign adr           = cpu_adr_i[15:0];
  assign unused_adr_hi = ^cpu_adr_i[PLEN-1:16];

  logic sel_ctrl, sel_hit, sel_ie, sel_cause, sel_npc, sel_gpr, gpr_nz, host_wr;
  assign sel_ctrl  = (adr == 16'h0000);
  assign sel_hit   = (adr == 16'h0001);
  assign sel_ie    = (adr == 16'h0002);
  assign sel_cause = (adr == 16'h0003);
  assign sel_npc   = (adr == 16'h0200);
  assign sel_gpr   = (adr[15:5] == 11'h020);
  assign gpr_nz    = (adr[4:0] != 5'd0);
  // Writes take effect only at the end of the ACCESS cycle, so a held strobe
  // can never write twice.
  assign host_wr   = (state_reg == ST_ACCESS) && cpu_we_i;

  logic ss_src, eb_src, exc_src, hw_src;
  logic [3:0] hit_set, hit_clr;
  assign ss_src  = !cpu_stall_i && ctrl_reg && ex_valid_i;
  assign eb_src  = !cpu_stall_i && ex_ebreak_i && ie_reg[3];
  assign exc_src = !cpu_stall_i && ex_exc_i && ie_reg[ex_cause_i];
  assign hit_set = {hw_src, exc_src, eb_src, ss_src};
  assign hit_clr = (host_wr && sel_hit) ? cpu_dat_i[3:0] : 4'd0;

  logic [XLEN-1:0] bp_rd;

`ifdef RISCV_DBG_HWBP_EN
  logic [XLEN-1:0] bpadr_reg [NBP];
  logic [NBP-1:0]  bpen_reg;
  logic [NBP-1:0]  bp_match, sel_bpadr, sel_bpctl;

  for (genvar gi = 0; gi < NBP; gi++) begin : g_bp
    assign sel_bpadr[gi] = (adr == (16'h0010 + 16'(gi)));
    assign sel_bpctl[gi] = (adr == (16'h0018 + 16'(gi)));
    assign bp_match[gi]  = bpen_reg[gi] && ex_valid_i && (ex_pc_i == bpadr_reg[gi]);
  end

  assign hw_src = !cpu_stall_i && (|bp_match);

  // Comparator address/enable registers, host-writable during ACCESS
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBP; i++) bpadr_reg[i] <= '0;
      bpen_reg <= '0;
    end else begin
      for (int i = 0; i < NBP; i++) begin
        if (host_wr && sel_bpadr[i]) bpadr_reg[i] <= cpu_dat_i;
        if (host_wr && sel_bpctl[i]) bpen_reg[i]  <= cpu_dat_i[0];
      end
    end
  end

  // Read-back of comparator registers
  always_comb begin
    bp_rd = '0;
    for (int i = 0; i < NBP; i++) begin
      if (sel_bpadr[i]) bp_rd = bpadr_reg[i];
      if (sel_bpctl[i]) bp_rd = XLEN'(bpen_reg[i]);
    end
  end
`else
  assign hw_src = 1'b0;
  assign bp_rd  = '0;
`endif

  // Read-data mux for register-backed locations; GPR data comes from the core
  logic [XLEN-1:0] rd_val;
  always_comb begin
    rd_val = '0;
    if (sel_ctrl)       rd_val = XLEN'(ctrl_reg);
    else if (sel_hit)   rd_val = XLEN'(hit_reg);
    else if (sel_ie)    rd_val = XLEN'(ie_reg);
    else if (sel_cause) rd_val = XLEN'(cause_reg);
    else if (sel_npc)   rd_val = npc_reg;
    else                rd_val = bp_rd;
  end

  // GPR read data arrives the cycle after gpr_re_o, i.e. during ACK
  assign cpu_dat_o = cpu_ack_o ? (rd_gpr_reg ? gpr_rdat_i : rdata_reg) : '0;
  assign npc_o     = npc_reg;

  // Bus handshake FSM, debug registers and breakpoint pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cpu_ack_o  <= 1'b0;
      cpu_bp_o   <= 1'b0;
      gpr_re_o   <= 1'b0;
      gpr_we_o   <= 1'b0;
      npc_we_o   <= 1'b0;
      gpr_idx_o  <= '0;
      gpr_wdat_o <= '0;
      rdata_reg  <= '0;
      rd_gpr_reg <= 1'b0;
      ctrl_reg   <= 1'b0;
      hit_reg    <= '0;
      ie_reg     <= '0;
      cause_reg  <= '0;
      npc_reg    <= '0;
    end else begin
      cpu_ack_o <= 1'b0;
      gpr_re_o  <= 1'b0;
      gpr_we_o  <= 1'b0;
      npc_we_o  <= 1'b0;
      cpu_bp_o  <= |hit_set;

      case (state_reg)
        ST_IDLE: begin
          if (cpu_stb_i) begin
            state_reg <= ST_ACCESS;
            gpr_idx_o <= adr[4:0];
            gpr_re_o  <= !cpu_we_i && sel_gpr && gpr_nz && cpu_stall_i;
          end
        end
        ST_ACCESS: begin
          state_reg  <= ST_ACK;
          cpu_ack_o  <= 1'b1;
          rdata_reg  <= rd_val;
          rd_gpr_reg <= gpr_re_o;
          if (cpu_we_i && sel_gpr && gpr_nz && cpu_stall_i) begin
            gpr_we_o   <= 1'b1;
            gpr_wdat_o <= cpu_dat_i;
          end
          if (cpu_we_i && sel_npc && cpu_stall_i) npc_we_o <= 1'b1;
        end
        ST_ACK:  state_reg <= ST_WAIT;
        default: if (!cpu_stb_i) state_reg <= ST_IDLE;
      endcase

      if (host_wr && sel_ctrl) ctrl_reg <= cpu_dat_i[0];
      if (host_wr && sel_ie)   ie_reg   <= cpu_dat_i[15:0];
      hit_reg <= (hit_reg & ~hit_clr) | hit_set;

      if (exc_src)               cause_reg <= ex_cause_i;
      else if (eb_src || hw_src) cause_reg <= 4'd3;

      if (host_wr && sel_npc && cpu_stall_i) npc_reg <= cpu_dat_i;
      else if (!cpu_stall_i && ex_valid_i)   npc_reg <= ex_pc_i;
    end
  end

endmodule
